sfixed_div_independent_seq: RTL and testbench

SFIXED_DIV_INDEPENDENT_SEQ -- requirements
Module: sfixed_div_independent_seq

---
 rtl/sfixed_pkg.sv | 25 ++
 rtl/sfixed_div_core.sv | 108 ++++++++++
 rtl/sfixed_div_independent_seq.sv | 101 ++++++++++
 tb/tb_sfixed_div_independent_seq.sv | 137 +++++++++++++
 4 files changed

// File: rtl/sfixed_pkg.sv
// rtl/sfixed_pkg.sv - shared FSM state, iteration count and output range helpers
package sfixed_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // One quotient bit per dividend bit after alignment: A_SIZE + shift.
  function automatic int calc_iter(input int a_left, input int a_right,
                                   input int b_right, input int out_right);
    return (a_left + a_right + 1) + (out_right + b_right - a_right);
  endfunction

  function automatic int out_max(input int out_left, input int out_right);
    return (1 << (out_left + out_right)) - 1;
  endfunction

  function automatic int out_min(input int out_left, input int out_right);
    return -(1 << (out_left + out_right));
  endfunction

endpackage

// File: rtl/sfixed_div_core.sv
// rtl/sfixed_div_core.sv - one restoring magnitude divider with sign/overflow fix-up
// Overflow and divide-by-zero saturate when SFIXED_DIV_SATURATE_EN is defined, else wrap / zero.
module sfixed_div_core
  import sfixed_pkg::*;
#(
  parameter int AW        = 8,
  parameter int BW        = 8,
  parameter int OW        = 16,
  parameter int SH        = 8,
  parameter int ITER      = 16,
  parameter int OUT_LEFT  = 7,
  parameter int OUT_RIGHT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          init,
  input  logic          step,
  input  logic          fix,
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  output logic [OW-1:0] q,
  output logic          div0
);

  localparam int WW = ((ITER > OW) ? ITER : OW) + 2;

  logic [AW-1:0]          a_r;
  logic [BW-1:0]          b_r;
  logic [AW-1:0]          a_mag;
  logic [BW-1:0]          b_mag;
  logic [BW-1:0]          bm;
  logic [BW-1:0]          rem;
  logic [ITER-1:0]        dq;
  logic [BW:0]            rem_sh;
  logic                   take;
  logic                   neg;
  logic                   b_zero;
  logic signed [WW-1:0]   q_w;
  logic [OW-1:0]          q_nxt;

`ifdef SFIXED_DIV_SATURATE_EN
  localparam logic signed [WW-1:0] MAX_W = signed'(WW'(out_max(OUT_LEFT, OUT_RIGHT)));
  localparam logic signed [WW-1:0] MIN_W = signed'(WW'(out_min(OUT_LEFT, OUT_RIGHT)));
  localparam logic [OW-1:0]        MAX_O = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0]        MIN_O = {1'b1, {(OW-1){1'b0}}};
  logic                 a_neg;
  logic signed [WW-1:0] res_w;
`endif

  always_comb begin
    a_mag  = a_r[AW-1] ? -a_r : a_r;
    b_mag  = b_r[BW-1] ? -b_r : b_r;
    // Remainder stays below |b|, so one extra bit covers the shifted trial value.
    rem_sh = {rem, dq[ITER-1]};
    take   = (rem_sh >= {1'b0, bm});
    q_w    = signed'(WW'(dq));
`ifdef SFIXED_DIV_SATURATE_EN
    res_w  = neg ? -q_w : q_w;
    if (b_zero)            q_nxt = a_neg ? MIN_O : MAX_O;
    else if (res_w > MAX_W) q_nxt = MAX_O;
    else if (res_w < MIN_W) q_nxt = MIN_O;
    else                    q_nxt = res_w[OW-1:0];
`else
    q_nxt  = b_zero ? '0 : OW'(neg ? -q_w : q_w);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      bm     <= '0;
      rem    <= '0;
      dq     <= '0;
      neg    <= 1'b0;
      b_zero <= 1'b0;
      q      <= '0;
      div0   <= 1'b0;
`ifdef SFIXED_DIV_SATURATE_EN
      a_neg  <= 1'b0;
`endif
    end else begin
      if (load) begin
        a_r <= a;
        b_r <= b;
      end
      if (init) begin
        bm     <= b_mag;
        rem    <= '0;
        dq     <= ITER'(a_mag) << SH;
        neg    <= a_r[AW-1] ^ b_r[BW-1];
        b_zero <= (b_r == '0);
`ifdef SFIXED_DIV_SATURATE_EN
        a_neg  <= a_r[AW-1];
`endif
      end else if (step) begin
        rem <= take ? BW'(rem_sh - {1'b0, bm}) : rem_sh[BW-1:0];
        dq  <= {dq[ITER-2:0], take};
      end
      if (fix) begin
        q    <= q_nxt;
        div0 <= b_zero;
      end
    end
  end

endmodule

// File: rtl/sfixed_div_independent_seq.sv
// rtl/sfixed_div_independent_seq.sv - three independent signed fixed-point dividers under one FSM
// Overflow/div0 handling selected by SFIXED_DIV_SATURATE_EN (see sfixed_div_core).
module sfixed_div_independent_seq
  import sfixed_pkg::*;
#(
  parameter int A_LEFT    = 3,
  parameter int A_RIGHT   = 4,
  parameter int B_LEFT    = 3,
  parameter int B_RIGHT   = 4,
  parameter int OUT_LEFT  = 7,
  parameter int OUT_RIGHT = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [A_LEFT+A_RIGHT:0]         a_x,
  input  logic [A_LEFT+A_RIGHT:0]         a_y,
  input  logic [A_LEFT+A_RIGHT:0]         a_z,
  input  logic [B_LEFT+B_RIGHT:0]         b_x,
  input  logic [B_LEFT+B_RIGHT:0]         b_y,
  input  logic [B_LEFT+B_RIGHT:0]         b_z,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_LEFT+OUT_RIGHT:0]     out_x,
  output logic [OUT_LEFT+OUT_RIGHT:0]     out_y,
  output logic [OUT_LEFT+OUT_RIGHT:0]     out_z,
  output logic [2:0]                      div0
);

  localparam int AW   = A_LEFT + A_RIGHT + 1;
  localparam int BW   = B_LEFT + B_RIGHT + 1;
  localparam int OW   = OUT_LEFT + OUT_RIGHT + 1;
  localparam int SH   = OUT_RIGHT + B_RIGHT - A_RIGHT;
  localparam int ITER = calc_iter(A_LEFT, A_RIGHT, B_RIGHT, OUT_RIGHT);
  localparam int CW   = $clog2(ITER + 1);

  if ((OUT_RIGHT + B_RIGHT < A_RIGHT) || (AW > 9) || (BW > 9)) begin : g_param_check
    $error("sfixed_div_independent_seq: unsupported operand/fraction parameters");
  end

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          accept, init, step, fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == S_CALC && state_nxt == S_CALC) ? cnt + 1'b1 : '0;
    end
  end

  // CALC spends its first cycle loading magnitudes, then ITER divide steps.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid)               state_nxt = S_CALC;
      S_CALC: if (cnt == CW'(ITER))       state_nxt = S_FIX;
      S_FIX:                              state_nxt = S_DONE;
      S_DONE: if (out_ready)              state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    accept    = in_valid && in_ready;
    init      = (state == S_CALC) && (cnt == '0);
    step      = (state == S_CALC) && (cnt != '0);
    fix       = (state == S_FIX);
  end

  sfixed_div_core #(
    .AW(AW), .BW(BW), .OW(OW), .SH(SH), .ITER(ITER),
    .OUT_LEFT(OUT_LEFT), .OUT_RIGHT(OUT_RIGHT)
  ) u_core_x (
    .clk(clk), .rst_n(rst_n), .load(accept), .init(init), .step(step), .fix(fix),
    .a(a_x), .b(b_x), .q(out_x), .div0(div0[0])
  );

  sfixed_div_core #(
    .AW(AW), .BW(BW), .OW(OW), .SH(SH), .ITER(ITER),
    .OUT_LEFT(OUT_LEFT), .OUT_RIGHT(OUT_RIGHT)
  ) u_core_y (
    .clk(clk), .rst_n(rst_n), .load(accept), .init(init), .step(step), .fix(fix),
    .a(a_y), .b(b_y), .q(out_y), .div0(div0[1])
  );

  sfixed_div_core #(
    .AW(AW), .BW(BW), .OW(OW), .SH(SH), .ITER(ITER),
    .OUT_LEFT(OUT_LEFT), .OUT_RIGHT(OUT_RIGHT)
  ) u_core_z (
    .clk(clk), .rst_n(rst_n), .load(accept), .init(init), .step(step), .fix(fix),
    .a(a_z), .b(b_z), .q(out_z), .div0(div0[2])
  );

endmodule

// File: tb/tb_sfixed_div_independent_seq.sv
// tb/tb_sfixed_div_independent_seq.sv - directed-vector bench for sfixed_div_independent_seq
module tb_sfixed_div_independent_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  a_x = '0, a_y = '0, a_z = '0, b_x = '0, b_y = '0, b_z = '0;
  logic        in_ready, out_valid;
  logic [15:0] out_x, out_y, out_z;
  logic [2:0]  div0;

  int errors = 0;
  int checks = 0;

`ifdef SFIXED_DIV_SATURATE_EN
  localparam logic [15:0] OVF_POS = 16'h7FFF;
  localparam logic [15:0] DZ_POS  = 16'h7FFF;
  localparam logic [15:0] DZ_NEG  = 16'h8000;
`else
  localparam logic [15:0] OVF_POS = 16'h8000;
  localparam logic [15:0] DZ_POS  = 16'h0000;
  localparam logic [15:0] DZ_NEG  = 16'h0000;
`endif

  sfixed_div_independent_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_x(a_x), .a_y(a_y), .a_z(a_z), .b_x(b_x), .b_y(b_y), .b_z(b_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .div0(div0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [7:0] ax, ay, az, bx, by, bz);
    @(negedge clk);
    in_valid = 1'b1;
    a_x = ax; a_y = ay; a_z = az;
    b_x = bx; b_y = by; b_z = bz;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(inout int cyc);
    while (!out_valid && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run(input string tag, input logic [7:0] ax, ay, az, bx, by, bz,
                     input logic [15:0] ex, ey, ez, input logic [2:0] ed);
    int cyc;
    issue(ax, ay, az, bx, by, bz);
    cyc = 0;
    wait_valid(cyc);
    check({tag, ".latency"}, cyc, 18);
    check({tag, ".x"}, out_x, ex);
    check({tag, ".y"}, out_y, ey);
    check({tag, ".z"}, out_z, ez);
    check({tag, ".div0"}, div0, ed);
    @(posedge clk); #1;
    check({tag, ".idle"}, in_ready, 1);
  endtask

  initial begin
    int cyc;
    logic [15:0] hx, hy, hz;

    #12;
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.out_x", out_x, 0);
    check("rst.div0", div0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run("v1", 8'h20, 8'hE8, 8'h10, 8'h08, 8'h04, 8'h30, 16'h0400, 16'hFA00, 16'h0055, 3'b000);
    run("v2", 8'hF0, 8'h80, 8'h80, 8'h30, 8'hFF, 8'h01, 16'hFFAB, OVF_POS, 16'h8000, 3'b000);
    run("v3", 8'h00, 8'h10, 8'hF0, 8'h30, 8'hD0, 8'hD0, 16'h0000, 16'hFFAB, 16'h0055, 3'b000);
    run("dz", 8'h10, 8'hF0, 8'h20, 8'h00, 8'h00, 8'h08, DZ_POS, DZ_NEG, 16'h0400, 3'b011);

    // Back-pressure plus an in_valid pulse while busy.
    out_ready = 1'b0;
    issue(8'h20, 8'hE8, 8'h10, 8'h08, 8'h04, 8'h30);
    cyc = 0;
    repeat (3) begin @(posedge clk); #1; cyc++; end
    in_valid = 1'b1;
    a_x = 8'h10; a_y = 8'h10; a_z = 8'h10; b_x = 8'h01; b_y = 8'h01; b_z = 8'h01;
    @(posedge clk); #1; cyc++;
    in_valid = 1'b0;
    check("busy.in_ready", in_ready, 0);
    wait_valid(cyc);
    check("hold.latency", cyc, 18);
    check("hold.x", out_x, 16'h0400);
    check("hold.y", out_y, 16'hFA00);
    check("hold.z", out_z, 16'h0055);
    hx = out_x; hy = out_y; hz = out_z;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold.valid", out_valid, 1);
      check("hold.in_ready", in_ready, 0);
      check("hold.stable", {out_x, out_y}, {hx, hy});
      check("hold.stable_z", {13'd0, div0, out_z}, {16'd0, hz});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release.out_valid", out_valid, 0);
    check("release.in_ready", in_ready, 1);

    // Reset in the middle of CALC.
    issue(8'h80, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'hFF);
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst.out_valid", out_valid, 0);
    check("midrst.in_ready", in_ready, 1);
    check("midrst.out_y", out_y, 0);
    check("midrst.div0", div0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run("post", 8'hE8, 8'h10, 8'h20, 8'h04, 8'h30, 8'h08, 16'hFA00, 16'h0055, 16'h0400, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
